booth_sequencer: RTL and testbench

Sequential radix-2 Booth multiplier with its own controller. It multiplies two signed WIDTH-bit operands one recode/shift step at a time. Steps advance only on cycles where the step_en tick is high, so the clock-divider tick can pace the visible progress of a multiplication on the board. Setting step_en high permanently gives full-speed operation. The block sits between the operand capture and the product display path, and it sequences the whole multiplication through a start/busy/done handshake.

---
 rtl/booth_sequencer.sv | 109 ++++++++++
 tb/tb_booth_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/booth_sequencer.sv
// booth_sequencer: sequential radix-2 Booth multiplier with a start/busy/done
// controller. One recode/shift step is taken per step_en tick while in STEP.
// step_en held high gives one step per clock.
module booth_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       step_en,
    input  logic                       start,
    input  logic [WIDTH-1:0]           multiplicand,
    input  logic [WIDTH-1:0]           multiplier,
    output logic                       busy,
    output logic                       done,
    output logic [2*WIDTH-1:0]         product,
    output logic [$clog2(WIDTH+1)-1:0] step_count
);
    localparam int CW = $clog2(WIDTH+1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] m_reg;
    logic [WIDTH:0]   a_reg;
    logic [WIDTH-1:0] q_reg;
    logic             q_1;

    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   a_sum;
    logic [WIDTH:0]   a_shift;
    logic [WIDTH-1:0] q_shift;
    logic             last_step;

    // M sign-extended to WIDTH+1 bits so the most negative M cannot overflow A
    assign m_ext     = {m_reg[WIDTH-1], m_reg};
    assign last_step = (step_count == CW'(WIDTH-1));

    assign busy = (state == STEP);
    assign done = (state == DONE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic: DONE always lasts exactly one cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = STEP;
            STEP:    if (step_en && last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Booth recode of {Q[0],q_1}, then arithmetic shift of {A,Q,q_1}
    always_comb begin
        a_sum = a_reg;
        case ({q_reg[0], q_1})
            2'b10:   a_sum = a_reg - m_ext;
            2'b01:   a_sum = a_reg + m_ext;
            default: a_sum = a_reg;
        endcase
        a_shift = {a_sum[WIDTH], a_sum[WIDTH:1]};
        q_shift = {a_sum[0], q_reg[WIDTH-1:1]};
    end

    // Datapath: operand load on accepted start, one step per tick, product on last step
    always_ff @(posedge clk) begin
        if (reset) begin
            m_reg      <= '0;
            a_reg      <= '0;
            q_reg      <= '0;
            q_1        <= 1'b0;
            step_count <= '0;
            product    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        m_reg      <= multiplicand;
                        a_reg      <= '0;
                        q_reg      <= multiplier;
                        q_1        <= 1'b0;
                        step_count <= '0;
                    end
                end
                STEP: begin
                    if (step_en) begin
                        a_reg      <= a_shift;
                        q_reg      <= q_shift;
                        q_1        <= q_reg[0];
                        step_count <= step_count + CW'(1);
                        if (last_step) product <= {a_shift[WIDTH-1:0], q_shift};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_sequencer.sv
// Bench for booth_sequencer: directed vector table plus randomized operations
// checked against plain signed multiplication and a tick-counting timing model.
module tb_booth_sequencer;
    localparam int W = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               step_en;
    logic               start;
    logic [W-1:0]       multiplicand;
    logic [W-1:0]       multiplier;
    logic               busy;
    logic               done;
    logic [2*W-1:0]     product;
    logic [$clog2(W+1)-1:0] step_count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [2*W-1:0] last_prod = '0;

    typedef struct {
        int         m;
        int         q;
        int         period;
        bit         e0_tick;
        bit         junk;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[11];

    booth_sequencer #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .step_en      (step_en),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .step_count   (step_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One multiplication; ticks arrive when (cycle index % period) == period-1,
    // counting cycles after the start edge. Optionally pulses junk starts in STEP and DONE.
    task automatic run_op(input int m, input int q, input int period, input bit e0_tick,
                          input bit junk, input logic [15:0] exp);
        int ticks;
        int cyc;
        bit te;
        multiplicand = W'(m);
        multiplier   = W'(q);
        start        = 1'b1;
        step_en      = e0_tick;
        next_cycle();
        start = 1'b0;
        ticks = 0;
        cyc   = 0;
        while (ticks < W && cyc < 500) begin
            chk("busy_in_step", 32'(busy), 1);
            chk("done_in_step", 32'(done), 0);
            chk("step_count", 32'(step_count), 32'(ticks));
            chk("product_held", 32'(product), 32'(last_prod));
            te = ((cyc % period) == period - 1);
            step_en = te;
            if (junk && cyc == 1) begin
                start        = 1'b1;
                multiplicand = ~W'(m);
                multiplier   = W'(q + 1);
            end else begin
                start = 1'b0;
            end
            next_cycle();
            cyc++;
            if (te) ticks++;
        end
        chk("steps_before_timeout", 32'(ticks), W);
        if (period == 1) chk("latency", 32'(cyc + 1), W + 1);
        chk("done", 32'(done), 1);
        chk("busy_in_done", 32'(busy), 0);
        chk("product", 32'(product), 32'(exp));
        chk("count_in_done", 32'(step_count), W);
        last_prod = exp;
        step_en = 1'($urandom_range(0, 1));
        start   = junk;
        if (junk) multiplicand = W'(m + 3);
        next_cycle();
        start = 1'b0;
        chk("done_one_cycle", 32'(done), 0);
        chk("busy_idle", 32'(busy), 0);
        chk("count_hold", 32'(step_count), W);
        chk("product_hold", 32'(product), 32'(last_prod));
        next_cycle();
        chk("idle_no_accept", 32'(busy), 0);
        chk("idle_no_done", 32'(done), 0);
    endtask

    initial begin
        int m, q, p;
        bit e0, jk;
        vecs[0]  = '{3,    5,    1, 1'b0, 1'b0, 16'h000F};
        vecs[1]  = '{-7,   6,    1, 1'b0, 1'b0, 16'hFFD6};
        vecs[2]  = '{6,    -7,   1, 1'b0, 1'b0, 16'hFFD6};
        vecs[3]  = '{-128, -128, 1, 1'b0, 1'b0, 16'h4000};
        vecs[4]  = '{127,  -128, 1, 1'b0, 1'b0, 16'hC080};
        vecs[5]  = '{-128, 1,    1, 1'b0, 1'b0, 16'hFF80};
        vecs[6]  = '{0,    -1,   1, 1'b0, 1'b0, 16'h0000};
        vecs[7]  = '{3,    5,    4, 1'b0, 1'b0, 16'h000F};
        vecs[8]  = '{3,    5,    4, 1'b1, 1'b0, 16'h000F};
        vecs[9]  = '{3,    5,    1, 1'b0, 1'b1, 16'h000F};
        vecs[10] = '{-7,   6,    3, 1'b0, 1'b1, 16'hFFD6};

        reset = 1'b1; step_en = 1'b0; start = 1'b0;
        multiplicand = '0; multiplier = '0;
        next_cycle();
        next_cycle();
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_product", 32'(product), 0);
        chk("reset_count", 32'(step_count), 0);
        reset = 1'b0;
        next_cycle();

        for (int i = 0; i < 11; i++)
            run_op(vecs[i].m, vecs[i].q, vecs[i].period, vecs[i].e0_tick, vecs[i].junk, vecs[i].exp);

        // Reset after three steps aborts the operation with no done pulse
        multiplicand = W'(100); multiplier = W'(-3);
        start = 1'b1; step_en = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (3) next_cycle();
        chk("mid_count", 32'(step_count), 3);
        reset = 1'b1;
        next_cycle();
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_product", 32'(product), 0);
        chk("abort_count", 32'(step_count), 0);
        reset = 1'b0;
        last_prod = '0;
        repeat (12) begin
            next_cycle();
            chk("no_done_after_abort", 32'(done), 0);
            chk("no_busy_after_abort", 32'(busy), 0);
        end
        run_op(3, 5, 1, 1'b0, 1'b0, 16'h000F);

        // Randomized operands, pacing and junk starts against signed multiplication
        for (int i = 0; i < 30; i++) begin
            m  = int'($urandom_range(0, 255)) - 128;
            q  = int'($urandom_range(0, 255)) - 128;
            p  = int'($urandom_range(1, 3));
            e0 = 1'($urandom_range(0, 1));
            jk = 1'($urandom_range(0, 1));
            run_op(m, q, p, e0, jk, 16'(m * q));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
